miso_fifo: RTL and testbench
============================

# miso_fifo

Multi-input single-output FIFO for the sequential router memory of the CNN accelerator. Each cycle it accepts up to DATA_LENGTH valid-masked lanes, compacts them in lane order and appends them to a circular buffer. It drains one output word per pop. In reduced-precision modes the output word packs several narrow elements. A rewind input replays the data written since the last clear, for operand reuse.

## Interface
- DEPTH, 32: number of element slots; power of two, ≥ DATA_LENGTH.
- DATA_WIDTH, 8: element width in bits; must be 8.
- DATA_LENGTH, 9: number of input lanes.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_nrst  in  1  reset; asynchronous and active-low.
- i_clear  in  1  synchronous flush: pointers, occupancy and written count go to 0.
- i_write_en  in  1  append the valid lanes of i_data.
- i_pop_en  in  1  request one output word.
- i_r_pointer_reset  in  1  rewind the read pointer to slot 0.
- i_p_mode  in  2  precision mode: 00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = treated as 00.
- i_data  in  DATA_LENGTH×DATA_WIDTH  lane data; lane k is i_data[k].
- i_valid  in  DATA_LENGTH  per-lane valid.
- o_data  out  DATA_WIDTH  popped word (registered).
- o_empty  out  1  occupancy == 0 (combinational).
- o_full  out  1  free slots < DATA_LENGTH (combinational).
- o_pop_valid  out  1  o_data carries a new pop result this cycle (registered).

## Operation
- **Storage:** DEPTH×DATA_WIDTH array, write pointer wp, read pointer rp, occupancy count cnt (0..DEPTH), and written count wc saturating at DEPTH.
- **Write** (i_write_en && !o_full):
  - The set lanes of i_valid are stored at wp, wp+1, … in ascending lane order, modulo DEPTH.
  - wp, cnt and wc advance by popcount(i_valid).
  - A write while o_full is dropped entirely.
- **Pack factor:** P = 1 / 2 / 4 for modes 00 / 01 / 10.
- **Pop** (i_pop_en && !o_empty):
  - Reads n = min(P, cnt) elements e0..e(n-1) starting at rp.
  - Mode 00: o_data = e0.
  - Mode 01: o_data = {e1[3:0], e0[3:0]}.
  - Mode 10: o_data = {e3[1:0], e2[1:0], e1[1:0], e0[1:0]}.
  - Missing elements (n < P) contribute zeros.
  - rp advances by n and cnt decreases by n. o_pop_valid = 1 on the next cycle.
- **Pop when empty:** o_pop_valid = 0 and o_data holds its value.
- **Simultaneous write and pop:** both take effect. The pop uses the pre-write cnt. The new cnt = cnt + written − n. o_full is evaluated on the pre-update cnt.
- **Rewind** (i_r_pointer_reset): rp = 0 and cnt = wc. Replay is exact only while wc < DEPTH and wp has not wrapped; beyond that, contents are whatever the slots hold.
- **Priority:** reset > i_clear > i_r_pointer_reset > write/pop. In a clear or rewind cycle, write and pop are ignored.
- **Mode changes:** take effect immediately. Stored data is unaffected.

## Timing
- **Reset values:** wp = rp = cnt = wc = 0, o_data = 0, o_pop_valid = 0, o_empty = 1, o_full = 0. Array contents are don't-care.
- Write-to-pop latency: data written at edge N is poppable at edge N+1. o_empty drops after edge N.
- Pop latency: i_pop_en sampled at edge N gives o_data and o_pop_valid valid after edge N, for one cycle per pop.
- Continuous pops deliver one word per cycle until empty. The pop that drains cnt to 0 is still valid.
- i_clear has no effect on data already registered in o_data. o_pop_valid is 0 in the cycle after a clear.

## Structure
- Shared package: p_mode enum (_8x8 = 2'b00, _4x4 = 2'b01, _2x2 = 2'b10), used by the router and PE array.
- Sub-module lane_compactor: combinational prefix-sum of i_valid giving each lane's slot offset and total count.
- Pointer, count and pack logic live in miso_fifo.

## Test plan
- **Reset:** hold i_nrst = 0 → o_empty = 1, o_full = 0, o_pop_valid = 0, o_data = 00.
- **8-bit write and drain:** mode 00, write lanes 0/1 = 11/22, then pop 2 cycles → o_data = 11 then 22 with o_pop_valid = 1 each. Then o_empty = 1; further pops give o_pop_valid = 0.
- **4-bit packing:** clear, mode 01, write lanes 0–4 = 01..05, then pop 6 cycles → 21, 43, 05 valid. The following 3 pops are invalid and o_data holds 05.
- **2-bit packing and compaction:** mode 10, i_valid = 9'b1_0000_0101, lane values 1, 2, 3 in lanes 0, 2, 8 → one pop gives 8'b00_11_10_01. Then empty.
- **Full:** DEPTH = 32, write 9 valid lanes three times → cnt = 27, o_full = 1. A fourth write is dropped. Pop 5 (mode 00) → cnt = 22, o_full = 0.
- **Rewind and clear:** write 4, pop 4, then pulse i_r_pointer_reset → cnt = 4 and the same 4 values replay. i_clear with i_write_en high → o_empty = 1 and nothing stored.

Source files
------------

// File: rtl/miso_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miso_fifo_pkg
//  Description : Shared types for the router memory and PE array. Provides
//                the precision-mode encoding and the pack-factor helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package miso_fifo_pkg;

    // Precision mode shared by the router and the PE array
    typedef enum logic [1:0] {
        _8x8 = 2'b00,
        _4x4 = 2'b01,
        _2x2 = 2'b10
    } p_mode_e;

    // Largest number of elements that can be packed into one output word
    localparam int c_MAX_PACK = 4;

    // Elements per output word for a mode; the unused encoding behaves as 8-bit
    function automatic logic [2:0] pack_factor(input logic [1:0] mode);
        case (p_mode_e'(mode))
            _4x4:    return 3'd2;
            _2x2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/miso_fifo_lane_compactor.sv
`default_nettype none
// ============================================================================
//  Module      : miso_fifo_lane_compactor
//  Description : Combinational prefix-sum over the lane valid mask. Each lane
//                gets the slot offset it will occupy after compaction, and
//                the total number of valid lanes is reported.
//  Revision    : 1.0 - initial release
// ============================================================================
module miso_fifo_lane_compactor
    import miso_fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 9,
    parameter int OFFW        = $clog2(DATA_LENGTH + 1)
) (
    input  logic [DATA_LENGTH-1:0]           i_valid,
    output logic [DATA_LENGTH-1:0][OFFW-1:0] o_offset,
    output logic [OFFW-1:0]                  o_count
);

    logic [OFFW-1:0] w_acc;

    // Running count of valid lanes below each lane gives its compacted offset
    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int k = 0; k < DATA_LENGTH; k++) begin
            o_offset[k] = w_acc;
            w_acc       = w_acc + OFFW'(i_valid[k]);
        end
        o_count = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/miso_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : miso_fifo
//  Description : Multi-input single-output FIFO. Appends the valid lanes of a
//                wide input word in lane order into a circular buffer and
//                drains one (optionally packed) output word per pop. A rewind
//                replays everything written since the last clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module miso_fifo
    import miso_fifo_pkg::*;
#(
    parameter int DEPTH       = 32,   // power of two, >= DATA_LENGTH
    parameter int DATA_WIDTH  = 8,    // packing logic assumes 8-bit elements
    parameter int DATA_LENGTH = 9
) (
    input  logic                                  i_clk,
    input  logic                                  i_nrst,
    input  logic                                  i_clear,
    input  logic                                  i_write_en,
    input  logic                                  i_pop_en,
    input  logic                                  i_r_pointer_reset,
    input  logic [1:0]                            i_p_mode,
    input  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] i_data,
    input  logic [DATA_LENGTH-1:0]                i_valid,
    output logic [DATA_WIDTH-1:0]                 o_data,
    output logic                                  o_empty,
    output logic                                  o_full,
    output logic                                  o_pop_valid
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CW   = $clog2(DEPTH + 1);
    localparam int c_OFFW = $clog2(DATA_LENGTH + 1);

    localparam logic [c_CW-1:0] c_DEPTH_CW = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_LEN_CW   = c_CW'(DATA_LENGTH);
    localparam logic [c_CW:0]   c_DEPTH_WIDE = (c_CW + 1)'(DEPTH);

    // Storage and state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wp;
    logic [c_AW-1:0]       r_rp;
    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       r_wc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_pop_valid;

    // Datapath wires
    logic [DATA_LENGTH-1:0][c_OFFW-1:0] w_offset;
    logic [c_OFFW-1:0]                  w_count;
    logic                               w_empty;
    logic                               w_full;
    logic                               w_wr_fire;
    logic                               w_pop_fire;
    logic [2:0]                         w_pack;
    logic [2:0]                         w_n;
    logic [c_MAX_PACK-1:0][DATA_WIDTH-1:0] w_elem;
    logic [DATA_WIDTH-1:0]              w_packed;
    logic [c_CW-1:0]                    w_cnt_next;
    logic [c_CW:0]                      w_wc_sum;
    logic [c_CW-1:0]                    w_wc_next;

    miso_fifo_lane_compactor #(
        .DATA_LENGTH (DATA_LENGTH),
        .OFFW        (c_OFFW)
    ) u_lane_compactor (
        .i_valid  (i_valid),
        .o_offset (w_offset),
        .o_count  (w_count)
    );

    // Status flags come straight from the pre-update occupancy
    assign w_empty = (r_cnt == '0);
    assign w_full  = ((c_DEPTH_CW - r_cnt) < c_LEN_CW);

    // Clear and rewind cycles suppress both data operations
    assign w_wr_fire  = i_write_en && !w_full  && !i_clear && !i_r_pointer_reset;
    assign w_pop_fire = i_pop_en   && !w_empty && !i_clear && !i_r_pointer_reset;

    // Number of elements consumed by a pop: pack factor clipped to occupancy
    always_comb begin
        w_pack = pack_factor(i_p_mode);
        if (r_cnt < c_CW'(w_pack)) begin
            w_n = r_cnt[2:0];
        end else begin
            w_n = w_pack;
        end
    end

    // Fetch up to four elements from the read pointer; missing ones read as 0
    always_comb begin
        w_elem = '0;
        for (int j = 0; j < c_MAX_PACK; j++) begin
            if (3'(j) < w_n) begin
                w_elem[j] = r_mem[r_rp + c_AW'(j)];
            end
        end
    end

    // Pack the fetched elements into one output word, lowest element in LSBs
    always_comb begin
        case (p_mode_e'(i_p_mode))
            _4x4:    w_packed = {w_elem[1][3:0], w_elem[0][3:0]};
            _2x2:    w_packed = {w_elem[3][1:0], w_elem[2][1:0],
                                 w_elem[1][1:0], w_elem[0][1:0]};
            default: w_packed = w_elem[0];
        endcase
    end

    // Next occupancy and saturating written count for a normal cycle
    always_comb begin
        w_cnt_next = r_cnt
                   + (w_wr_fire  ? c_CW'(w_count) : '0)
                   - (w_pop_fire ? c_CW'(w_n)     : '0);
        w_wc_sum   = {1'b0, r_wc} + (w_wr_fire ? (c_CW + 1)'(w_count) : '0);
        w_wc_next  = (w_wc_sum >= c_DEPTH_WIDE) ? c_DEPTH_CW : w_wc_sum[c_CW-1:0];
    end

    // Pointer, count and output register update with clear/rewind priority
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_wc        <= '0;
            r_data      <= '0;
            r_pop_valid <= 1'b0;
        end else if (i_clear) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_wc        <= '0;
            r_pop_valid <= 1'b0;
        end else if (i_r_pointer_reset) begin
            r_rp        <= '0;
            r_cnt       <= r_wc;
            r_pop_valid <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wp <= r_wp + c_AW'(w_count);
                r_wc <= w_wc_next;
            end
            if (w_pop_fire) begin
                r_rp   <= r_rp + c_AW'(w_n);
                r_data <= w_packed;
            end
            r_cnt       <= w_cnt_next;
            r_pop_valid <= w_pop_fire;
        end
    end

    // Scatter the valid lanes into consecutive slots; contents need no reset
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DATA_LENGTH; k++) begin
            if (w_wr_fire && i_valid[k]) begin
                r_mem[r_wp + c_AW'(w_offset[k])] <= i_data[k];
            end
        end
    end

    assign o_data      = r_data;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_pop_valid = r_pop_valid;

endmodule
`default_nettype wire

// File: tb/tb_miso_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miso_fifo
//  Description : Self-checking bench for miso_fifo. A queue-based model of
//                the FIFO contents predicts flags and popped words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miso_fifo;

    localparam int DEPTH = 32;
    localparam int DW    = 8;
    localparam int DL    = 9;

    logic               clk = 1'b0;
    logic               nrst;
    logic               clear;
    logic               we;
    logic               pop;
    logic               rw;
    logic [1:0]         mode;
    logic [DL-1:0][DW-1:0] data;
    logic [DL-1:0]      valid;
    logic [DW-1:0]      o_data;
    logic               o_empty;
    logic               o_full;
    logic               o_pop_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending elements, history since last clear, outputs
    logic [7:0] q[$];
    logic [7:0] hist[$];
    logic [7:0] m_data;
    logic       m_pv;

    miso_fifo #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DW),
        .DATA_LENGTH (DL)
    ) dut (
        .i_clk             (clk),
        .i_nrst            (nrst),
        .i_clear           (clear),
        .i_write_en        (we),
        .i_pop_en          (pop),
        .i_r_pointer_reset (rw),
        .i_p_mode          (mode),
        .i_data            (data),
        .i_valid           (valid),
        .o_data            (o_data),
        .o_empty           (o_empty),
        .o_full            (o_full),
        .o_pop_valid       (o_pop_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pfac(input logic [1:0] m);
        if (m == 2'b01) return 2;
        if (m == 2'b10) return 4;
        return 1;
    endfunction

    function automatic logic [DL-1:0][DW-1:0] rnd_data();
        logic [DL-1:0][DW-1:0] r;
        for (int k = 0; k < DL; k++) r[k] = 8'($urandom);
        return r;
    endfunction

    // One clock cycle: drive, check flags, advance model, check registered outputs
    task automatic cycle(input bit c, input bit w, input bit p, input bit r,
                         input logic [1:0] m, input logic [DL-1:0] v,
                         input logic [DL-1:0][DW-1:0] d);
        int         pf;
        int         n;
        bit         full;
        logic [7:0] e[4];
        clear = c; we = w; pop = p; rw = r; mode = m; valid = v; data = d;
        #1;
        full = (DEPTH - q.size()) < DL;
        chk("empty", 32'(o_empty), 32'(q.size() == 0));
        chk("full",  32'(o_full),  32'(full));
        if (c) begin
            q.delete();
            hist.delete();
            m_pv = 1'b0;
        end else if (r) begin
            q    = hist;
            m_pv = 1'b0;
        end else begin
            m_pv = 1'b0;
            if (p && q.size() > 0) begin
                pf = pfac(m);
                n  = (pf < q.size()) ? pf : q.size();
                for (int j = 0; j < 4; j++) begin
                    e[j] = 8'h00;
                    if (j < n) e[j] = q.pop_front();
                end
                case (pf)
                    2:       m_data = {e[1][3:0], e[0][3:0]};
                    4:       m_data = {e[3][1:0], e[2][1:0], e[1][1:0], e[0][1:0]};
                    default: m_data = e[0];
                endcase
                m_pv = 1'b1;
            end
            if (w && !full) begin
                for (int k = 0; k < DL; k++) begin
                    if (v[k]) begin
                        q.push_back(d[k]);
                        if (hist.size() < DEPTH) hist.push_back(d[k]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pop_valid", 32'(o_pop_valid), 32'(m_pv));
        chk("data",      32'(o_data),      32'(m_data));
    endtask

    initial begin
        logic [DL-1:0][DW-1:0] d;
        logic [DL-1:0][DW-1:0] saved;
        bit rc, rr;

        // Reset state
        nrst = 1'b0; clear = 1'b0; we = 1'b0; pop = 1'b0; rw = 1'b0;
        mode = 2'b00; valid = '0; data = '0;
        m_data = 8'h00; m_pv = 1'b0;
        #3;
        chk("rst_empty", 32'(o_empty),     32'd1);
        chk("rst_full",  32'(o_full),      32'd0);
        chk("rst_pv",    32'(o_pop_valid), 32'd0);
        chk("rst_data",  32'(o_data),      32'h00);
        @(posedge clk); #1;
        nrst = 1'b1;

        // 8-bit write and drain
        d = '0; d[0] = 8'h11; d[1] = 8'h22;
        cycle(0, 1, 0, 0, 2'b00, 9'h003, d);
        cycle(0, 0, 1, 0, 2'b00, '0, d);
        chk("b8_first", 32'(o_data), 32'h11);
        cycle(0, 0, 1, 0, 2'b00, '0, d);
        chk("b8_second", 32'(o_data), 32'h22);
        chk("b8_empty", 32'(o_empty), 32'd1);
        cycle(0, 0, 1, 0, 2'b00, '0, d);
        chk("b8_nopop", 32'(o_pop_valid), 32'd0);

        // 4-bit packing
        cycle(1, 0, 0, 0, 2'b01, '0, d);
        d = '0; for (int k = 0; k < 5; k++) d[k] = 8'(k + 1);
        cycle(0, 1, 0, 0, 2'b01, 9'h01F, d);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 2'b01, '0, d);
        chk("b4_hold", 32'(o_data), 32'h05);

        // 2-bit packing with compaction of sparse lanes
        d = '0; d[0] = 8'd1; d[2] = 8'd2; d[8] = 8'd3;
        cycle(0, 1, 0, 0, 2'b10, 9'b1_0000_0101, d);
        cycle(0, 0, 1, 0, 2'b10, '0, d);
        chk("b2_word", 32'(o_data), 32'h39);
        chk("b2_empty", 32'(o_empty), 32'd1);

        // Full threshold and dropped write
        cycle(1, 0, 0, 0, 2'b00, '0, d);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 2'b00, 9'h1FF, rnd_data());
        chk("full_set", 32'(o_full), 32'd1);
        cycle(0, 1, 0, 0, 2'b00, 9'h1FF, rnd_data());
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 2'b00, '0, d);
        chk("full_clr", 32'(o_full), 32'd0);
        chk("full_cnt", 32'(q.size()), 32'd22);

        // Rewind replay, then clear with write enable held
        cycle(1, 0, 0, 0, 2'b00, '0, d);
        saved = rnd_data();
        cycle(0, 1, 0, 0, 2'b00, 9'h00F, saved);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 2'b00, '0, d);
        cycle(0, 1, 1, 1, 2'b00, 9'h1FF, rnd_data());
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 2'b00, '0, d);
            chk("replay", 32'(o_data), 32'(saved[i]));
        end
        cycle(1, 1, 0, 0, 2'b00, 9'h1FF, rnd_data());
        chk("clr_empty", 32'(o_empty), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 39) == 0);
            rr = (hist.size() < DEPTH) && ($urandom_range(0, 19) == 0);
            cycle(rc, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) < ((i < 200) ? 1 : 3)), rr,
                  2'($urandom_range(0, 3)), 9'($urandom), rnd_data());
        end

        // Asynchronous reset mid-cycle clears registered outputs at once
        cycle(0, 1, 0, 0, 2'b00, 9'h003, rnd_data());
        cycle(0, 0, 1, 0, 2'b00, '0, d);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_pv",    32'(o_pop_valid), 32'd0);
        chk("arst_data",  32'(o_data),      32'h00);
        chk("arst_empty", 32'(o_empty),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
